usi_dispatch_ctrl: RTL and testbench
====================================

# usi_dispatch_ctrl

Parametrised top-level dispatcher for the USI. It accepts transfer triggers, latches a mode index, enables exactly one of NUM_ENGINES serial engines, and supervises that engine with a watchdog and an abort path. It reports a per-transaction completion status and a saturating error count. It sits between the USI register/trigger logic and the UART/I2C/SPI engines, and extends to further engines without changing the FSM.

## Interface
- NUM_ENGINES, 3, number of engines; mode index i drives eng_en[i] (0=UART, 1=I2C, 2=SPI)
- MODE_W, 2, mode field width; must satisfy 2**MODE_W >= NUM_ENGINES
- TIMEOUT_W, 16, watchdog counter and timeout_cycles width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  global USI enable; gates new triggers only
- tx_req  in  1  transmit trigger
- rx_activity  in  1  receive trigger
- mode  in  MODE_W  requested engine index; sampled in DISPATCH
- abort  in  1  software abort request
- timeout_cycles  in  TIMEOUT_W  watchdog limit in ACTIVE cycles; 0 disables the watchdog
- eng_done  in  NUM_ENGINES  per-engine done; only the bit of the latched mode is observed
- eng_err  in  NUM_ENGINES  per-engine error; only the bit of the latched mode is observed
- usi_busy  out  1  high in DISPATCH and ACTIVE
- engines_off  out  1  low only in ACTIVE
- latch_mode  out  1  high in DISPATCH
- eng_en  out  NUM_ENGINES  one-hot; bit [mode_q] high in ACTIVE, otherwise all 0
- done_pulse  out  1  high for exactly one cycle, in RETURN_IDLE
- status  out  3  last result: 0 OK, 1 ENG_ERR, 2 TIMEOUT, 3 BAD_MODE, 4 ABORT
- status_mode  out  MODE_W  mode of the last transaction
- err_count  out  8  count of non-OK completions; saturates at 255
- pending  out  1  one-deep queued trigger flag

## Operation
- States: IDLE, DISPATCH, ACTIVE, RETURN_IDLE. All flop updates are on the rising edge of clk.
- trig = enable & (tx_req | rx_activity).
- IDLE → DISPATCH when trig | pending. pending clears on this transition.
- In any non-IDLE state, trig sets pending. A further trig while pending is already set is dropped.
- If a trig coincides with the IDLE→DISPATCH transition, pending ends clear and that trig is consumed.
- DISPATCH:
  - mode_q <= mode.
  - If mode < NUM_ENGINES, go to ACTIVE and clear the watchdog counter.
  - Otherwise go to RETURN_IDLE with status BAD_MODE.
  - abort in DISPATCH overrides both and goes to RETURN_IDLE with status ABORT.
- ACTIVE exit conditions, evaluated in this priority order each cycle:
  1. eng_err[mode_q] → ENG_ERR
  2. eng_done[mode_q] → OK
  3. abort → ABORT
  4. timeout_cycles != 0 and cnt == timeout_cycles-1 → TIMEOUT
  5. Otherwise stay in ACTIVE and increment cnt.
- Done/err bits of non-selected engines are ignored.
- On every entry to RETURN_IDLE:
  - status and status_mode are loaded.
  - err_count increments if the loaded status != OK, saturating at 255.
- RETURN_IDLE → IDLE unconditionally.
- Deasserting enable never ends a transaction in progress.
- Illegal state encoding → IDLE with all outputs at their IDLE values.
- Reset values: state IDLE, pending 0, mode_q 0, cnt 0, usi_busy 0, engines_off 1, latch_mode 0, eng_en 0, done_pulse 0, status 0, status_mode 0, err_count 0.
- Reset has priority over all events, including mid-ACTIVE. eng_en drops the cycle after rst is sampled high.

## Timing
- Trigger sampled at edge N → DISPATCH from cycle N+1. ACTIVE (eng_en high) from cycle N+2.
- Engine done/err sampled at edge K → RETURN_IDLE in cycle K+1, with done_pulse and the new status visible. IDLE in cycle K+2.
- Minimum transaction: IDLE → IDLE in 4 cycles. A queued pending trigger restarts DISPATCH in the cycle after IDLE is re-entered.
- Watchdog: ACTIVE lasts at most timeout_cycles cycles. timeout_cycles is sampled live.
- BAD_MODE / ABORT from DISPATCH: RETURN_IDLE follows DISPATCH directly, and eng_en never asserts.
- All outputs are registered-state Moore decodes; there are no combinational input-to-output paths.

## Test plan
- Reset, then enable=1, tx_req pulse, mode=1, eng_done[1] high 5 cycles after eng_en[1] rises:
  - eng_en=3'b010 for exactly 6 cycles, done_pulse once, status=0, status_mode=1, err_count=0.
- mode=3 with NUM_ENGINES=3:
  - DISPATCH → RETURN_IDLE, eng_en stays 0, status=3, err_count=1.
- timeout_cycles=4, mode=2, no done:
  - eng_en[2] high exactly 4 cycles, status=2.
  - Repeat with timeout_cycles=0 and hold 100 cycles: still ACTIVE, then eng_done[2] → status=0.
- eng_err[0] and eng_done[0] asserted in the same cycle, with eng_done[1] also high:
  - status=1. eng_done[1] is ignored during a mode-0 transaction.
- rx_activity pulse during ACTIVE:
  - pending=1; after RETURN_IDLE, IDLE lasts one cycle, then DISPATCH; pending clears.
- abort in ACTIVE → status=4.
- rst pulsed mid-ACTIVE → all outputs at reset values the next cycle.
- 256 consecutive BAD_MODE transactions → err_count holds at 255.

Source files
------------

// File: rtl/usi_dispatch_ctrl_if.sv
// ---------------------------------------------------------------------------
// usi_dispatch_ctrl_if
// Bundles the trigger/engine-facing signals of the USI dispatcher.
//   master : USI register/trigger side plus engine feedback (drives requests,
//            observes enables and completion status)
//   slave  : the dispatcher itself
// Signals:
//   enable, tx_req, rx_activity, mode, abort, timeout_cycles -> dispatcher
//   eng_done, eng_err (per engine)                           -> dispatcher
//   usi_busy, engines_off, latch_mode, eng_en, done_pulse,
//   status, status_mode, err_count, pending                  <- dispatcher
// ---------------------------------------------------------------------------
interface usi_dispatch_ctrl_if #(
  parameter int unsigned NUM_ENGINES = 3,
  parameter int unsigned MODE_W      = 2,
  parameter int unsigned TIMEOUT_W   = 16
);
  logic                   enable;
  logic                   tx_req;
  logic                   rx_activity;
  logic [MODE_W-1:0]      mode;
  logic                   abort;
  logic [TIMEOUT_W-1:0]   timeout_cycles;
  logic [NUM_ENGINES-1:0] eng_done;
  logic [NUM_ENGINES-1:0] eng_err;

  logic                   usi_busy;
  logic                   engines_off;
  logic                   latch_mode;
  logic [NUM_ENGINES-1:0] eng_en;
  logic                   done_pulse;
  logic [2:0]             status;
  logic [MODE_W-1:0]      status_mode;
  logic [7:0]             err_count;
  logic                   pending;

  modport master (
    output enable, tx_req, rx_activity, mode, abort, timeout_cycles,
           eng_done, eng_err,
    input  usi_busy, engines_off, latch_mode, eng_en, done_pulse,
           status, status_mode, err_count, pending
  );

  modport slave (
    input  enable, tx_req, rx_activity, mode, abort, timeout_cycles,
           eng_done, eng_err,
    output usi_busy, engines_off, latch_mode, eng_en, done_pulse,
           status, status_mode, err_count, pending
  );
endinterface

// File: rtl/usi_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// usi_dispatch_ctrl
// Top-level USI dispatcher. Accepts transmit/receive triggers, latches the
// requested mode, enables exactly one serial engine and supervises it with a
// watchdog and an abort path. Reports a per-transaction status, the mode of
// the last transaction and a saturating error count.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : usi_dispatch_ctrl_if.slave (triggers, mode, abort, watchdog limit,
//          engine done/err in; enables, state flags, status out)
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module usi_dispatch_ctrl #(
  parameter int unsigned NUM_ENGINES = 3,
  parameter int unsigned MODE_W      = 2,
  parameter int unsigned TIMEOUT_W   = 16
) (
  input logic                clk,
  input logic                rst,
  usi_dispatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_DISPATCH    = 2'd1,
    S_ACTIVE      = 2'd2,
    S_RETURN_IDLE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_ENG_ERR  = 3'd1,
    ST_TIMEOUT  = 3'd2,
    ST_BAD_MODE = 3'd3,
    ST_ABORT    = 3'd4
  } status_e;

  localparam logic [MODE_W:0] NUM_ENG_L = (MODE_W+1)'(NUM_ENGINES);

  state_e                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic [MODE_W-1:0]      mode_q, mode_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  status_e                status_q, status_d;
  logic [MODE_W-1:0]      status_mode_q, status_mode_d;
  logic [7:0]             err_count_q, err_count_d;

  logic                   trig;
  logic                   mode_ok;
  logic [NUM_ENGINES-1:0] sel_oh;
  logic                   sel_done;
  logic                   sel_err;
  logic                   tmo_hit;
  logic                   ret_load;
  status_e                ret_status;

  assign trig    = bus.enable & (bus.tx_req | bus.rx_activity);
  assign mode_ok = ({1'b0, bus.mode} < NUM_ENG_L);

  // Selection decode built by comparison rather than bit-indexing so that
  // MODE_W may be wider than the minimum needed for NUM_ENGINES.
  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      sel_oh[i] = (mode_q == MODE_W'(i));
    end
  end

  assign sel_done = |(bus.eng_done & sel_oh);
  assign sel_err  = |(bus.eng_err  & sel_oh);
  assign tmo_hit  = (bus.timeout_cycles != '0) &&
                    (cnt_q == (bus.timeout_cycles - TIMEOUT_W'(1)));

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    ret_load   = 1'b0;
    ret_status = ST_OK;

    case (state_q)
      S_IDLE: begin
        if (trig || pending_q) begin
          state_d = S_DISPATCH;
        end
      end

      S_DISPATCH: begin
        mode_d = bus.mode;
        if (bus.abort) begin
          state_d    = S_RETURN_IDLE;
          ret_load   = 1'b1;
          ret_status = ST_ABORT;
        end else if (mode_ok) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
        end else begin
          state_d    = S_RETURN_IDLE;
          ret_load   = 1'b1;
          ret_status = ST_BAD_MODE;
        end
      end

      S_ACTIVE: begin
        if (sel_err) begin
          state_d    = S_RETURN_IDLE;
          ret_load   = 1'b1;
          ret_status = ST_ENG_ERR;
        end else if (sel_done) begin
          state_d    = S_RETURN_IDLE;
          ret_load   = 1'b1;
          ret_status = ST_OK;
        end else if (bus.abort) begin
          state_d    = S_RETURN_IDLE;
          ret_load   = 1'b1;
          ret_status = ST_ABORT;
        end else if (tmo_hit) begin
          state_d    = S_RETURN_IDLE;
          ret_load   = 1'b1;
          ret_status = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end

      S_RETURN_IDLE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pending: any trigger outside IDLE is queued (one deep); leaving IDLE
  // consumes both the queued flag and any coincident trigger.
  always_comb begin
    pending_d = 1'b0;
    if (state_q != S_IDLE) begin
      pending_d = pending_q | trig;
    end
  end

  // Status capture on every entry to RETURN_IDLE. mode_d already holds the
  // freshly sampled mode when the exit is taken straight from DISPATCH.
  always_comb begin
    status_d      = status_q;
    status_mode_d = status_mode_q;
    err_count_d   = err_count_q;
    if (ret_load) begin
      status_d      = ret_status;
      status_mode_d = mode_d;
      if ((ret_status != ST_OK) && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pending_q     <= 1'b0;
      mode_q        <= '0;
      cnt_q         <= '0;
      status_q      <= ST_OK;
      status_mode_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      status_q      <= status_d;
      status_mode_q <= status_mode_d;
      err_count_q   <= err_count_d;
    end
  end

  // Moore output decode
  logic                   usi_busy;
  logic                   engines_off;
  logic                   latch_mode;
  logic [NUM_ENGINES-1:0] eng_en;
  logic                   done_pulse;

  always_comb begin
    usi_busy    = 1'b0;
    engines_off = 1'b1;
    latch_mode  = 1'b0;
    eng_en      = '0;
    done_pulse  = 1'b0;
    case (state_q)
      S_DISPATCH: begin
        usi_busy   = 1'b1;
        latch_mode = 1'b1;
      end
      S_ACTIVE: begin
        usi_busy    = 1'b1;
        engines_off = 1'b0;
        eng_en      = sel_oh;
      end
      S_RETURN_IDLE: begin
        done_pulse = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.usi_busy    = usi_busy;
  assign bus.engines_off = engines_off;
  assign bus.latch_mode  = latch_mode;
  assign bus.eng_en      = eng_en;
  assign bus.done_pulse  = done_pulse;
  assign bus.status      = status_q;
  assign bus.status_mode = status_mode_q;
  assign bus.err_count   = err_count_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_usi_dispatch_ctrl.sv
module tb_usi_dispatch_ctrl;
  localparam int NE = 3;
  localparam int MW = 2;
  localparam int TW = 16;

  // Transaction kinds driven by the stimulus
  localparam int K_DONE      = 0;
  localparam int K_ERR       = 1;
  localparam int K_ERRDONE   = 2;
  localparam int K_ABORT_ACT = 3;
  localparam int K_NONE      = 4;
  localparam int K_ABORT_DSP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usi_dispatch_ctrl_if #(.NUM_ENGINES(NE), .MODE_W(MW), .TIMEOUT_W(TW)) bus ();

  usi_dispatch_ctrl #(.NUM_ENGINES(NE), .MODE_W(MW), .TIMEOUT_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int st;
    int md;
    int ec;
    int len;
    int en;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   err_model = 0;
  int   act_len = 0;
  int   seen_en = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Reference model: transaction outcome from mode, event kind, event cycle
  // and watchdog limit.
  task automatic predict(input int m, input int kind, input int d, input int tc);
    exp_t x;
    if (kind == K_ABORT_DSP) begin
      x.st = 4; x.len = 0;
    end else if (m >= NE) begin
      x.st = 3; x.len = 0;
    end else if (tc != 0 && (kind == K_NONE || tc <= d)) begin
      x.st = 2; x.len = tc;
    end else begin
      x.len = d + 1;
      case (kind)
        K_DONE:      x.st = 0;
        K_ERR:       x.st = 1;
        K_ERRDONE:   x.st = 1;
        default:     x.st = 4;
      endcase
    end
    if (x.st != 0 && err_model < 255) err_model++;
    x.md = m;
    x.ec = err_model;
    x.en = (x.len > 0) ? (1 << m) : 0;
    exp_q.push_back(x);
  endtask

  // Monitor: counts engine-enable cycles and checks each completion.
  always @(negedge clk) begin
    if (rst) begin
      act_len = 0;
      seen_en = 0;
    end else begin
      if (bus.eng_en != '0) begin
        act_len++;
        seen_en = seen_en | int'(bus.eng_en);
      end
      if (bus.done_pulse) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: status %0d with no expected transaction", bus.status);
        end else begin
          e = exp_q.pop_front();
          chk("status", int'(bus.status), e.st);
          chk("status_mode", int'(bus.status_mode), e.md);
          chk("err_count", int'(bus.err_count), e.ec);
          chk("active_cycles", act_len, e.len);
          chk("eng_en_pattern", seen_en, e.en);
        end
        act_len = 0;
        seen_en = 0;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_usi_busy"}, int'(bus.usi_busy), 0);
    chk({tag, "_engines_off"}, int'(bus.engines_off), 1);
    chk({tag, "_latch_mode"}, int'(bus.latch_mode), 0);
    chk({tag, "_eng_en"}, int'(bus.eng_en), 0);
    chk({tag, "_done_pulse"}, int'(bus.done_pulse), 0);
    chk({tag, "_status"}, int'(bus.status), 0);
    chk({tag, "_status_mode"}, int'(bus.status_mode), 0);
    chk({tag, "_err_count"}, int'(bus.err_count), 0);
    chk({tag, "_pending"}, int'(bus.pending), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.usi_busy || bus.done_pulse) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 1, 0);
  endtask

  task automatic noise(input logic [NE-1:0] sel);
    bus.eng_done = NE'($urandom) & ~sel;
    bus.eng_err  = NE'($urandom) & ~sel;
  endtask

  task automatic run_txn(input int m, input int kind, input int d, input int tc);
    logic [NE-1:0] sel;
    int dd;
    sel = (m < NE) ? NE'(1 << m) : '0;
    dd  = (kind == K_NONE) ? tc + 2 : d;
    predict(m, kind, d, tc);
    @(negedge clk);
    bus.mode = MW'(m);
    bus.timeout_cycles = TW'(tc);
    if ($urandom_range(0, 1) == 0) bus.tx_req = 1'b1;
    else bus.rx_activity = 1'b1;
    @(negedge clk);
    bus.tx_req = 1'b0;
    bus.rx_activity = 1'b0;
    if (kind == K_ABORT_DSP) bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    // Dropping enable must not disturb the transaction in flight.
    bus.enable = ($urandom_range(0, 3) != 0);
    if (m < NE && kind != K_ABORT_DSP) begin
      for (int c = 0; c < dd; c++) begin
        noise(sel);
        @(negedge clk);
      end
      noise(sel);
      case (kind)
        K_DONE:      bus.eng_done = bus.eng_done | sel;
        K_ERR:       bus.eng_err  = sel;
        K_ERRDONE:   begin bus.eng_err = sel; bus.eng_done = '1; end
        K_ABORT_ACT: bus.abort = 1'b1;
        default: ;
      endcase
      @(negedge clk);
      bus.eng_done = '0;
      bus.eng_err  = '0;
      bus.abort    = 1'b0;
    end
    wait_idle();
    bus.enable = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m, kind, d, tc, n;
    bus.enable = 1'b0;
    bus.tx_req = 1'b0;
    bus.rx_activity = 1'b0;
    bus.mode = '0;
    bus.abort = 1'b0;
    bus.timeout_cycles = '0;
    bus.eng_done = '0;
    bus.eng_err = '0;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Triggers ignored while disabled
    @(negedge clk);
    bus.tx_req = 1'b1;
    @(negedge clk);
    bus.tx_req = 1'b0;
    chk("disabled_no_dispatch", int'(bus.latch_mode) + int'(bus.usi_busy), 0);
    @(negedge clk);
    chk("disabled_still_idle", int'(bus.usi_busy), 0);
    bus.enable = 1'b1;

    // Directed cases
    run_txn(1, K_DONE, 5, 0);        // eng_en 6 cycles, OK
    run_txn(3, K_DONE, 0, 0);        // BAD_MODE
    run_txn(2, K_NONE, 0, 4);        // TIMEOUT after 4 ACTIVE cycles
    run_txn(2, K_DONE, 100, 0);      // watchdog disabled
    run_txn(0, K_ERRDONE, 2, 0);     // err beats done; other done ignored
    run_txn(1, K_ABORT_ACT, 3, 0);   // abort in ACTIVE
    run_txn(0, K_ABORT_DSP, 0, 0);   // abort in DISPATCH
    run_txn(2, K_DONE, 0, 1);        // done beats timeout on same cycle
    run_txn(1, K_DONE, 3, 3);        // timeout before done

    // Pending trigger queued during ACTIVE; queued transaction is BAD_MODE
    predict(1, K_DONE, 2, 0);
    predict(3, K_DONE, 0, 0);
    @(negedge clk);
    bus.mode = 2'd1;
    bus.timeout_cycles = '0;
    bus.tx_req = 1'b1;
    @(negedge clk);
    bus.tx_req = 1'b0;
    @(negedge clk);
    bus.rx_activity = 1'b1;
    bus.mode = 2'd3;
    @(negedge clk);
    bus.rx_activity = 1'b0;
    chk("pending_set", int'(bus.pending), 1);
    @(negedge clk);
    bus.eng_done = 3'b010;
    @(negedge clk);
    bus.eng_done = '0;
    chk("pending_held_return", int'(bus.pending) + 2 * int'(bus.done_pulse), 3);
    @(negedge clk);
    chk("pending_idle_gap", int'(bus.usi_busy) + 2 * int'(bus.pending), 2);
    @(negedge clk);
    chk("pending_redispatch", int'(bus.latch_mode), 1);
    chk("pending_cleared", int'(bus.pending), 0);
    @(negedge clk);
    wait_idle();

    // Randomized transactions
    for (int i = 0; i < 150; i++) begin
      m    = $urandom_range(0, 3);
      kind = $urandom_range(0, 5);
      d    = $urandom_range(0, 15);
      tc   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
      if (kind == K_NONE && tc == 0) tc = $urandom_range(1, 12);
      run_txn(m, kind, d, tc);
    end

    // Reset mid-ACTIVE with a queued trigger
    @(negedge clk);
    bus.mode = 2'd1;
    bus.timeout_cycles = '0;
    bus.tx_req = 1'b1;
    @(negedge clk);
    bus.tx_req = 1'b0;
    n = 0;
    while (bus.eng_en == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reached_active", int'(bus.eng_en), 2);
    bus.rx_activity = 1'b1;
    @(negedge clk);
    bus.rx_activity = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst");
    err_model = 0;
    @(negedge clk);
    rst = 1'b0;

    // Saturation of the error count
    for (int i = 0; i < 260; i++) run_txn(3, K_DONE, 0, 0);
    chk("err_count_saturated", int'(bus.err_count), 255);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
